// File: rtl/clk_div_param.sv
// -----------------------------------------------------------------------------
// clk_div_param
//
// Run-time programmable integer clock divider. Divides i_ref_clk by a ratio N
// in the range 2 .. 2^DIV_W-1. A ratio below 2, or a deasserted enable, selects
// BYPASS, where the reference clock is passed straight through. Ratio, enable
// and bypass changes are sampled only at divided-period boundaries. As a result,
// reconfiguration never shortens a high or low phase of the output.
//
// For a latched ratio N, each period is H = floor(N/2) high cycles followed by
// N-H low cycles. A one-cycle tick marks the first high cycle of every period.
//
// Ports
//   i_ref_clk    in   1      reference clock, all flops on its rising edge
//   i_rst        in   1      asynchronous active-high reset
//   i_clk_en     in   1      divider enable, sampled at boundaries / in BYPASS
//   i_div_ratio  in   DIV_W  requested ratio N (N < 2 selects BYPASS)
//   o_div_clk    out  1      divided clock, or i_ref_clk in BYPASS
//   o_div_tick   out  1      strobe in the first high cycle of each period
//   o_active     out  1      high while dividing (RUN)
//   o_cur_ratio  out  DIV_W  ratio in effect, 0 in BYPASS
// -----------------------------------------------------------------------------
module clk_div_param #(
    parameter int DIV_W = 8
) (
    input  logic             i_ref_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    input  logic [DIV_W-1:0] i_div_ratio,
    output logic             o_div_clk,
    output logic             o_div_tick,
    output logic             o_active,
    output logic [DIV_W-1:0] o_cur_ratio
);

    typedef enum logic {
        ST_BYPASS = 1'b0,
        ST_RUN    = 1'b1
    } state_e;

    // Registered state
    state_e           r_state;
    logic [DIV_W-1:0] r_ratio;
    logic [DIV_W-1:0] r_cnt;
    logic             r_div;
    logic             r_tick;

    // Next-state values
    state_e           w_state_nxt;
    logic [DIV_W-1:0] w_ratio_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_div_nxt;
    logic             w_tick_nxt;

    // Datapath helpers
    logic [DIV_W-1:0] w_half;
    logic [DIV_W-1:0] w_cnt_inc;
    logic             w_last;
    logic             w_req_ok;

    // r_ratio is at least 2 whenever r_state is RUN, so r_ratio-1 cannot underflow
    // while w_last is in use. The counter stops at r_ratio-1 and never wraps.
    assign w_half    = r_ratio >> 1;
    assign w_cnt_inc = r_cnt + DIV_W'(1);
    assign w_last    = (r_cnt == (r_ratio - DIV_W'(1)));
    assign w_req_ok  = i_clk_en && (i_div_ratio >= DIV_W'(2));

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves
        // one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_ratio_nxt = r_ratio;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_tick_nxt  = 1'b0;

        unique case (r_state)
            ST_BYPASS: begin
                // Entry occurs on a rising reference edge. The pass-through clock
                // is high at that edge, and r_div also starts high, so the output
                // mux changes source between two high inputs.
                if (w_req_ok) begin
                    w_state_nxt = ST_RUN;
                    w_ratio_nxt = i_div_ratio;
                    w_cnt_nxt   = '0;
                    w_div_nxt   = 1'b1;
                    w_tick_nxt  = 1'b1;
                end
            end

            ST_RUN: begin
                if (!w_last) begin
                    w_cnt_nxt = w_cnt_inc;
                    w_div_nxt = (w_cnt_inc < w_half);
                end else if (!w_req_ok) begin
                    // Exit happens only after the final low cycle. The bypass
                    // clock then starts from this rising edge.
                    w_state_nxt = ST_BYPASS;
                    w_ratio_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_div_nxt   = 1'b0;
                end else begin
                    // A new period starts here. It uses whatever ratio is
                    // present at this edge.
                    w_ratio_nxt = i_div_ratio;
                    w_cnt_nxt   = '0;
                    w_div_nxt   = 1'b1;
                    w_tick_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_BYPASS;
            end
        endcase
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_BYPASS;
            r_ratio <= '0;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop take its value from
            // the state before this edge, independent of statement order.
            r_state <= w_state_nxt;
            r_ratio <= w_ratio_nxt;
            r_cnt   <= w_cnt_nxt;
            r_div   <= w_div_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // The mux select is a register, so it changes only on a rising reference edge.
    assign o_div_clk   = (r_state == ST_RUN) ? r_div : i_ref_clk;
    assign o_div_tick  = r_tick;
    assign o_active    = (r_state == ST_RUN);
    assign o_cur_ratio = (r_state == ST_RUN) ? r_ratio : '0;

endmodule

// File: tb/tb_clk_div_param.sv
// -----------------------------------------------------------------------------
// tb_clk_div_param
//
// Directed bench for clk_div_param (DIV_W = 8). Inputs change just after a
// falling edge. Outputs are sampled on falling edges, and 1 time unit after a
// rising edge when the bypass clock's high level is being observed. At each
// falling edge the bench sits inside one reference cycle of the divided period.
// -----------------------------------------------------------------------------
module tb_clk_div_param;

    localparam int DIV_W = 8;

    logic             clk;
    logic             rst;
    logic             clk_en;
    logic [DIV_W-1:0] div_ratio;
    logic             div_clk;
    logic             div_tick;
    logic             active;
    logic [DIV_W-1:0] cur_ratio;

    int checks;
    int errors;

    clk_div_param #(.DIV_W(DIV_W)) dut (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_clk_en    (clk_en),
        .i_div_ratio (div_ratio),
        .o_div_clk   (div_clk),
        .o_div_tick  (div_tick),
        .o_active    (active),
        .o_cur_ratio (cur_ratio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int idx,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    // Checks one full divided period: n cycles, with the first h cycles high.
    // If drop_at >= 0, the enable is deasserted at that cycle (mid-period).
    // The task must be called at the falling edge inside cycle 0. It returns at
    // the falling edge inside cycle 0 of the following period.
    task automatic check_period(input string tag, input int n, input int h,
                                input int cur, input int drop_at);
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) clk_en = 1'b0;
            check({tag, "_clk"},   i, 32'(div_clk),   32'(i < h));
            check({tag, "_tick"},  i, 32'(div_tick),  32'(i == 0));
            check({tag, "_act"},   i, 32'(active),    32'd1);
            check({tag, "_ratio"}, i, 32'(cur_ratio), 32'(cur));
            @(negedge clk);
        end
    endtask

    // Checks that the DUT is in bypass for a number of cycles. The divided
    // clock must follow the reference clock low and high, with no tick.
    task automatic check_bypass(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check({tag, "_lo"},    i, 32'(div_clk),   32'd0);
            check({tag, "_act"},   i, 32'(active),    32'd0);
            check({tag, "_tick"},  i, 32'(div_tick),  32'd0);
            check({tag, "_ratio"}, i, 32'(cur_ratio), 32'd0);
            @(posedge clk);
            #1;
            check({tag, "_hi"},    i, 32'(div_clk),   32'd1);
            check({tag, "_tickh"}, i, 32'(div_tick),  32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        clk_en    = 1'b0;
        div_ratio = '0;

        // Reset values. The output follows the reference clock in both phases.
        #1;
        check("rst_clk_lo", 0, 32'(div_clk),   32'd0);
        check("rst_tick",   0, 32'(div_tick),  32'd0);
        check("rst_act",    0, 32'(active),    32'd0);
        check("rst_ratio",  0, 32'(cur_ratio), 32'd0);
        @(posedge clk);
        #1;
        check("rst_clk_hi", 0, 32'(div_clk),   32'd1);

        // N=4: entry at the first rising edge, pattern 1,1,0,0 repeating.
        @(negedge clk);
        rst       = 1'b0;
        clk_en    = 1'b1;
        div_ratio = 8'd4;
        @(negedge clk);
        check_period("n4a", 4, 2, 4, -1);
        check_period("n4b", 4, 2, 4, -1);
        check_period("n4c", 4, 2, 4, -1);

        // N=5 is requested mid-period. The current N=4 period completes first.
        div_ratio = 8'd5;
        check_period("n4to5", 4, 2, 4, -1);
        check_period("n5a",   5, 2, 5, -1);
        check_period("n5b",   5, 2, 5, -1);

        // N=3, then switch to 6 in the 2nd cycle of an N=3 period.
        div_ratio = 8'd3;
        check_period("n5to3", 5, 2, 5, -1);
        check_period("n3a",   3, 1, 3, -1);
        check("sw_clk0",   0, 32'(div_clk),   32'd1);
        check("sw_tick0",  0, 32'(div_tick),  32'd1);
        @(negedge clk);
        div_ratio = 8'd6;
        check("sw_clk1",   1, 32'(div_clk),   32'd0);
        check("sw_ratio1", 1, 32'(cur_ratio), 32'd3);
        @(negedge clk);
        check("sw_clk2",   2, 32'(div_clk),   32'd0);
        check("sw_ratio2", 2, 32'(cur_ratio), 32'd3);
        @(negedge clk);
        check_period("n6a", 6, 3, 6, -1);

        // N=7 with the enable dropped in cycle 3. Expect a full 3/4 period,
        // then bypass.
        div_ratio = 8'd7;
        check_period("n6to7", 6, 3, 6, -1);
        check_period("n7off", 7, 3, 7, 3);
        check_bypass("byp_off", 3);

        // Reassert the enable. RUN is entered on the next rising edge.
        clk_en = 1'b1;
        @(negedge clk);
        check_period("n7re", 7, 3, 7, -1);

        // N=0, then N=1, with the enable held. The DUT stays in bypass.
        div_ratio = 8'd0;
        check_period("n7to0", 7, 3, 7, -1);
        check_bypass("byp_n0", 3);
        div_ratio = 8'd1;
        check_bypass("byp_n1", 3);

        // N=255 gives 127 high / 128 low. N=10 is queued mid-period.
        div_ratio = 8'd255;
        @(negedge clk);
        div_ratio = 8'd10;
        check_period("n255", 255, 127, 255, -1);

        // Reset during cycle 0 (high phase, tick high) of an N=10 period.
        check("pre_rst_clk",  0, 32'(div_clk),  32'd1);
        check("pre_rst_tick", 0, 32'(div_tick), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_clk",   0, 32'(div_clk),   32'd0);
        check("mid_rst_tick",  0, 32'(div_tick),  32'd0);
        check("mid_rst_act",   0, 32'(active),    32'd0);
        check("mid_rst_ratio", 0, 32'(cur_ratio), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_hi",    0, 32'(div_clk),   32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_period("n10a", 10, 5, 10, -1);
        check_period("n10b", 10, 5, 10, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
